// File: rtl/hazard3_muldiv_arb_pkg.sv
// Shared definitions for the two-port muldiv arbiter: M-extension op
// encodings, FSM state type, and the operand-reuse hit-set decode.
package hazard3_muldiv_arb_pkg;

  localparam int W_MULOP_DEF = 3;

  // Op encodings match the core's decode (funct3 with bit 2 inverted).
  localparam logic [2:0] M_OP_DIV    = 3'b000;
  localparam logic [2:0] M_OP_DIVU   = 3'b001;
  localparam logic [2:0] M_OP_REM    = 3'b010;
  localparam logic [2:0] M_OP_REMU   = 3'b011;
  localparam logic [2:0] M_OP_MUL    = 3'b100;
  localparam logic [2:0] M_OP_MULH   = 3'b101;
  localparam logic [2:0] M_OP_MULHSU = 3'b110;
  localparam logic [2:0] M_OP_MULHU  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // True when the unit's held result for last_op also answers new_op.
  // MUL is computed as an unsigned product by the unit, so its high half
  // is a valid MULHU result; the reverse direction holds for any MULH*.
  function automatic logic reuse_hit_pair(input logic [2:0] last_op,
                                          input logic [2:0] new_op);
    logic hit;
    hit = (last_op == new_op);
    case (last_op)
      M_OP_DIV:                          hit = hit | (new_op == M_OP_REM);
      M_OP_REM:                          hit = hit | (new_op == M_OP_DIV);
      M_OP_DIVU:                         hit = hit | (new_op == M_OP_REMU);
      M_OP_REMU:                         hit = hit | (new_op == M_OP_DIVU);
      M_OP_MUL:                          hit = hit | (new_op == M_OP_MULHU);
      M_OP_MULH, M_OP_MULHSU, M_OP_MULHU: hit = hit | (new_op == M_OP_MUL);
      default:                           ;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/hazard3_muldiv_reuse_chk.sv
// Remembers the operands of the last op sent to the muldiv unit and flags
// a candidate request that can be answered from the unit's held result.
module hazard3_muldiv_reuse_chk
  import hazard3_muldiv_arb_pkg::*;
#(
  parameter int W_DATA   = 32,
  parameter int W_MULOP  = W_MULOP_DEF,
  parameter bit REUSE_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               capture,     // op issued to the unit this cycle
  input  logic               complete,    // unit result delivered this cycle
  input  logic               invalidate,  // in-flight op killed this cycle
  input  logic [W_MULOP-1:0] cand_op,
  input  logic [W_DATA-1:0]  cand_a,
  input  logic [W_DATA-1:0]  cand_b,
  output logic               hit
);

  logic               reuse_vld;
  logic [W_MULOP-1:0] last_op;
  logic [W_DATA-1:0]  last_a;
  logic [W_DATA-1:0]  last_b;

  // Held result is trustworthy only between a clean completion and the next issue or kill.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reuse_vld <= 1'b0;
    end else if (complete) begin
      reuse_vld <= 1'b1;
    end else if (capture || invalidate) begin
      reuse_vld <= 1'b0;
    end
  end

  // Capture the operands that the unit is about to work on.
  // NOTE: no reset on these data registers; reuse_vld gates every use of them.
  always_ff @(posedge clk) begin
    if (capture) begin
      last_op <= cand_op;
      last_a  <= cand_a;
      last_b  <= cand_b;
    end
  end

  assign hit = REUSE_EN && reuse_vld
            && (cand_a == last_a) && (cand_b == last_b)
            && reuse_hit_pair(last_op[2:0], cand_op[2:0]);

endmodule

// File: rtl/hazard3_muldiv_arb.sv
// Shares one sequential multiply/divide unit between two requesters:
// round-robin grant, per-port kill, result routing, operand-reuse fast path.
module hazard3_muldiv_arb
  import hazard3_muldiv_arb_pkg::*;
#(
  parameter int W_DATA   = 32,
  parameter int W_MULOP  = W_MULOP_DEF,
  parameter bit REUSE_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_vld,
  output logic [1:0]           req_rdy,
  input  logic [2*W_MULOP-1:0] req_op,
  input  logic [2*W_DATA-1:0]  req_a,
  input  logic [2*W_DATA-1:0]  req_b,
  input  logic [1:0]           req_kill,
  output logic [1:0]           resp_vld,
  output logic [W_DATA-1:0]    resp_h,
  output logic [W_DATA-1:0]    resp_l,
  output logic [W_MULOP-1:0]   md_op,
  output logic                 md_vld,
  input  logic                 md_rdy,
  output logic                 md_kill,
  output logic [W_DATA-1:0]    md_a,
  output logic [W_DATA-1:0]    md_b,
  input  logic [W_DATA-1:0]    md_result_h,
  input  logic [W_DATA-1:0]    md_result_l,
  input  logic                 md_result_vld
);

  arb_state_e         state;
  logic               owner;     // port whose op is in the unit while BUSY
  logic               rr_ptr;    // port with priority at the next grant
  logic               hit_pend;  // reuse hit answered this cycle
  logic               hit_port;

  logic [1:0]         cand;
  logic               sel_port;  // port presented to the unit / reuse checker
  logic [W_MULOP-1:0] sel_op;
  logic [W_DATA-1:0]  sel_a;
  logic [W_DATA-1:0]  sel_b;
  logic               reuse_hit;

  logic               issue;
  logic               grant_hit;
  logic               complete;
  logic               owner_kill;

  // A killed port never competes in the cycle its kill is raised.
  assign cand = req_vld & ~req_kill;

  // In IDLE the round-robin winner is presented; in BUSY only the
  // non-owner can be issued (alongside a kill of the owner).
  always_comb begin
    if (state == ST_BUSY) begin
      sel_port = ~owner;
    end else begin
      sel_port = cand[rr_ptr] ? rr_ptr : ~rr_ptr;
    end
  end

  assign sel_op = sel_port ? req_op[2*W_MULOP-1:W_MULOP] : req_op[W_MULOP-1:0];
  assign sel_a  = sel_port ? req_a[2*W_DATA-1:W_DATA]    : req_a[W_DATA-1:0];
  assign sel_b  = sel_port ? req_b[2*W_DATA-1:W_DATA]    : req_b[W_DATA-1:0];

  hazard3_muldiv_reuse_chk #(
    .W_DATA   (W_DATA),
    .W_MULOP  (W_MULOP),
    .REUSE_EN (REUSE_EN)
  ) u_reuse_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture    (issue),
    .complete   (complete),
    .invalidate (owner_kill),
    .cand_op    (sel_op),
    .cand_a     (sel_a),
    .cand_b     (sel_b),
    .hit        (reuse_hit)
  );

  // Decide this cycle's action: grant/issue, reuse hit, completion or kill.
  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    issue      = 1'b0;
    grant_hit  = 1'b0;
    complete   = 1'b0;
    owner_kill = 1'b0;
    req_rdy    = 2'b00;
    resp_vld   = 2'b00;

    if (state == ST_IDLE) begin
      if (md_rdy && !hit_pend && (cand != 2'b00)) begin
        grant_hit = reuse_hit;
        issue     = !reuse_hit;
      end
      if (hit_pend && !req_kill[hit_port]) begin
        resp_vld[hit_port] = 1'b1;
      end
    end else begin
      owner_kill = req_kill[owner];
      if (owner_kill) begin
        issue = cand[sel_port];
      end else if (md_result_vld) begin
        complete        = 1'b1;
        resp_vld[owner] = 1'b1;
      end
    end

    if (issue || grant_hit) begin
      req_rdy[sel_port] = 1'b1;
    end
  end

  assign md_vld  = issue;
  assign md_kill = owner_kill;
  assign md_op   = sel_op;
  assign md_a    = sel_a;
  assign md_b    = sel_b;
  assign resp_h  = md_result_h;
  assign resp_l  = md_result_l;

  // Arbitration FSM: ownership, round-robin pointer and reuse-hit pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      rr_ptr   <= 1'b0;
      hit_pend <= 1'b0;
      hit_port <= 1'b0;
    end else begin
      hit_pend <= grant_hit;
      if (grant_hit) begin
        hit_port <= sel_port;
      end
      case (state)
        ST_IDLE: begin
          if (issue) begin
            state <= ST_BUSY;
            owner <= sel_port;
          end
        end
        ST_BUSY: begin
          if (owner_kill) begin
            rr_ptr <= ~owner;
            if (issue) begin
              owner <= sel_port;
            end else begin
              state <= ST_IDLE;
            end
          end else if (complete) begin
            state  <= ST_IDLE;
            rr_ptr <= ~owner;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard3_muldiv_arb.sv
// Bench for hazard3_muldiv_arb: directed scenarios plus randomized
// single-port traffic checked against an arithmetic reference model.
module tb_hazard3_muldiv_arb;
  import hazard3_muldiv_arb_pkg::*;

  localparam int W_DATA  = 32;
  localparam int W_MULOP = 3;

  // Pairs (last -> new) whose held unit result answers the new op.
  localparam logic [5:0] HIT_PAIRS [8] = '{
    {M_OP_DIV,    M_OP_REM},  {M_OP_REM,  M_OP_DIV},
    {M_OP_DIVU,   M_OP_REMU}, {M_OP_REMU, M_OP_DIVU},
    {M_OP_MULH,   M_OP_MUL},  {M_OP_MULHSU, M_OP_MUL},
    {M_OP_MULHU,  M_OP_MUL},  {M_OP_MUL,  M_OP_MULHU}
  };

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [1:0]           req_vld = '0;
  logic [1:0]           req_rdy;
  logic [2*W_MULOP-1:0] req_op = '0;
  logic [2*W_DATA-1:0]  req_a = '0;
  logic [2*W_DATA-1:0]  req_b = '0;
  logic [1:0]           req_kill = '0;
  logic [1:0]           resp_vld;
  logic [W_DATA-1:0]    resp_h, resp_l;
  logic [W_MULOP-1:0]   md_op;
  logic                 md_vld, md_rdy, md_kill;
  logic [W_DATA-1:0]    md_a, md_b;
  logic [W_DATA-1:0]    md_result_h, md_result_l;
  logic                 md_result_vld;

  int n_chk  = 0;
  int n_fail = 0;
  int md_lat = 4;
  int resp_cnt0 = 0;
  int resp_cnt1 = 0;

  always #5 clk = ~clk;

  hazard3_muldiv_arb #(
    .W_DATA(W_DATA), .W_MULOP(W_MULOP), .REUSE_EN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_kill(req_kill),
    .resp_vld(resp_vld), .resp_h(resp_h), .resp_l(resp_l),
    .md_op(md_op), .md_vld(md_vld), .md_rdy(md_rdy), .md_kill(md_kill),
    .md_a(md_a), .md_b(md_b),
    .md_result_h(md_result_h), .md_result_l(md_result_l),
    .md_result_vld(md_result_vld)
  );

  // RISC-V M semantics; returns {high, low}. MUL yields the unsigned product.
  function automatic logic [63:0] ref_calc(input logic [2:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p = '0; q = '0; r = '0;
    case (op)
      M_OP_MUL, M_OP_MULHU: p = 64'(ua * ub);
      M_OP_MULH:            p = 64'(sa * sb);
      M_OP_MULHSU:          p = 64'(sa * ub);
      M_OP_DIV, M_OP_REM: begin
        if (b == 0) begin q = '1; r = a; end
        else begin q = 32'(sa / sb); r = 32'(sa % sb); end
      end
      default: begin
        if (b == 0) begin q = '1; r = a; end
        else begin q = a / b; r = a % b; end
      end
    endcase
    return op[2] ? p : {r, q};
  endfunction

  // The half of the result that the op architecturally returns.
  function automatic logic [31:0] rel_half(input logic [2:0] op, input logic [63:0] v);
    return (op == M_OP_MUL || op == M_OP_DIV || op == M_OP_DIVU) ? v[31:0] : v[63:32];
  endfunction

  function automatic bit pair_ok(input logic [2:0] l, input logic [2:0] n);
    if (l == n) return 1'b1;
    foreach (HIT_PAIRS[i]) if (HIT_PAIRS[i] == {l, n}) return 1'b1;
    return 1'b0;
  endfunction

  // Sequential muldiv unit model: md_lat cycles per op, holds its result.
  logic        u_busy;
  int          u_cnt;
  logic [2:0]  u_op;
  logic [31:0] u_a, u_b;
  assign md_rdy = !u_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_busy <= 1'b0; u_cnt <= 0; u_op <= '0; u_a <= '0; u_b <= '0;
      md_result_vld <= 1'b0; md_result_h <= '0; md_result_l <= '0;
    end else begin
      md_result_vld <= 1'b0;
      if (md_vld && (md_rdy || md_kill)) begin
        u_busy <= 1'b1; u_cnt <= md_lat; u_op <= md_op; u_a <= md_a; u_b <= md_b;
      end else if (md_kill) begin
        u_busy <= 1'b0;
      end else if (u_busy) begin
        if (u_cnt <= 1) begin
          u_busy <= 1'b0;
          md_result_vld <= 1'b1;
          {md_result_h, md_result_l} <= ref_calc(u_op, u_a, u_b);
        end else begin
          u_cnt <= u_cnt - 1;
        end
      end
    end
  end

  // Count every response strobe per port.
  always @(negedge clk) begin
    if (resp_vld[0]) resp_cnt0 <= resp_cnt0 + 1;
    if (resp_vld[1]) resp_cnt1 <= resp_cnt1 + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_vld[p] = v;
    req_op[p*3 +: 3] = op;
    req_a[p*32 +: 32] = a;
    req_b[p*32 +: 32] = b;
  endtask

  // Waits (bounded) for req_rdy[p]; returns at posedge+1 after the grant cycle.
  task automatic wait_grant(input int p, input string tag, output bit md_seen, output bit ok);
    ok = 1'b0; md_seen = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (req_rdy[p]) begin ok = 1'b1; md_seen = md_vld; end
      @(posedge clk); #1;
    end
    if (!ok) check({tag, " grant timeout"}, 0, 1);
  endtask

  // Waits (bounded) for resp_vld[p]; lat counts cycles after the call.
  task automatic wait_resp(input int p, input string tag, output logic [63:0] res, output int lat);
    bit ok;
    ok = 1'b0; res = 'x; lat = -1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (resp_vld[p]) begin ok = 1'b1; res = {resp_h, resp_l}; lat = t; end
      @(posedge clk); #1;
    end
    if (!ok) check({tag, " resp timeout"}, 0, 1);
  endtask

  task automatic run_op(input int p, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit exp_hit, input string tag,
                        output logic [63:0] res);
    bit md_seen, ok;
    int lat;
    res = 'x;
    set_req(p, 1'b1, op, a, b);
    wait_grant(p, tag, md_seen, ok);
    req_vld[p] = 1'b0;
    if (ok) begin
      check({tag, " md_vld"}, 64'(md_seen), 64'(!exp_hit));
      wait_resp(p, tag, res, lat);
      if (exp_hit) check({tag, " hit latency"}, 64'(lat), 0);
      check({tag, " result"}, 64'(rel_half(op, res)), 64'(rel_half(op, ref_calc(op, a, b))));
    end
  endtask

  task automatic do_reset();
    req_vld = '0; req_kill = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] res;
    bit md_seen, ok, early, exp_hit;
    int c0, c1, lat, p;
    logic [2:0] op;
    logic [31:0] a, b, m_a, m_b;
    logic [2:0] m_op;
    bit m_vld;

    // Reset state
    @(negedge clk);
    check("rst req_rdy", 64'(req_rdy), 0);
    check("rst resp_vld", 64'(resp_vld), 0);
    check("rst md_vld", 64'(md_vld), 0);
    check("rst md_kill", 64'(md_kill), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Port0 DIVU 100/7 alone, then rr_ptr must favour port1
    run_op(0, M_OP_DIVU, 100, 7, 1'b0, "t1 divu", res);
    check("t1 divu full", res, {32'd2, 32'd14});
    set_req(0, 1'b1, M_OP_MUL, 3, 5);
    set_req(1, 1'b1, M_OP_MUL, 4, 5);
    @(negedge clk);
    check("t1 rr grant", 64'(req_rdy), 64'(2'b10));
    @(posedge clk); #1;
    req_vld = '0;
    wait_resp(1, "t1 drain", res, lat);
    check("t1 drain result", 64'(res[31:0]), 20);

    // Simultaneous requests after reset: port0 first, port1 right after
    do_reset();
    set_req(0, 1'b1, M_OP_MUL, 3, 5);
    set_req(1, 1'b1, M_OP_MUL, 6, 7);
    @(negedge clk);
    check("t2 first grant", 64'(req_rdy), 64'(2'b01));
    check("t2 first md_vld", 64'(md_vld), 1);
    @(posedge clk); #1;
    req_vld[0] = 1'b0;
    early = 1'b0; ok = 1'b0; res = 'x;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (req_rdy[1]) early = 1'b1;
      if (resp_vld[0]) begin ok = 1'b1; res = {resp_h, resp_l}; end
      @(posedge clk); #1;
    end
    check("t2 p0 result", 64'(res[31:0]), 15);
    check("t2 p1 early grant", 64'(early), 0);
    @(negedge clk);
    check("t2 p1 grant", 64'(req_rdy), 64'(2'b10));
    @(posedge clk); #1;
    req_vld[1] = 1'b0;
    wait_resp(1, "t2 p1", res, lat);
    check("t2 p1 result", 64'(res[31:0]), 42);

    // REM then DIV on same operands answered from the held result
    run_op(0, M_OP_REM, 32'hFFFF_FFF9, 2, 1'b0, "t3 rem", res);
    check("t3 rem high", 64'(res[63:32]), 64'(32'hFFFF_FFFF));
    run_op(0, M_OP_DIV, 32'hFFFF_FFF9, 2, 1'b1, "t3 div", res);
    check("t3 div low", 64'(res[31:0]), 64'(32'hFFFF_FFFD));

    // MULHU -> MUL hits; MULHU -> MULH misses
    run_op(1, M_OP_MULHU, 32'hFFFF_FFFF, 2, 1'b0, "t4 mulhu", res);
    run_op(1, M_OP_MUL, 32'hFFFF_FFFF, 2, 1'b1, "t4 mul", res);
    check("t4 mul full", res, {32'd1, 32'hFFFF_FFFE});
    run_op(1, M_OP_MULH, 32'hFFFF_FFFF, 2, 1'b0, "t4 mulh", res);

    // MULH -> MUL hit, killed while pending: no response
    c1 = resp_cnt1;
    set_req(1, 1'b1, M_OP_MUL, 32'hFFFF_FFFF, 2);
    wait_grant(1, "t4k", md_seen, ok);
    req_vld[1] = 1'b0;
    check("t4k md_vld", 64'(md_seen), 0);
    req_kill[1] = 1'b1;
    @(negedge clk);
    check("t4k resp_vld", 64'(resp_vld), 0);
    @(posedge clk); #1;
    req_kill[1] = 1'b0;
    @(posedge clk); #1;
    check("t4k resp count", 64'(resp_cnt1 - c1), 0);

    // Kill port0 DIV 5 cycles in while port1 MUL waits: kill + reissue
    md_lat = 12;
    c0 = resp_cnt0;
    set_req(0, 1'b1, M_OP_DIV, 1000, 7);
    wait_grant(0, "t5 div", md_seen, ok);
    req_vld[0] = 1'b0;
    check("t5 div md_vld", 64'(md_seen), 1);
    set_req(1, 1'b1, M_OP_MUL, 2, 3);
    early = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (req_rdy[1]) early = 1'b1;
      @(posedge clk); #1;
    end
    check("t5 p1 early grant", 64'(early), 0);
    req_kill[0] = 1'b1;
    @(negedge clk);
    check("t5 md_kill", 64'(md_kill), 1);
    check("t5 md_vld", 64'(md_vld), 1);
    check("t5 req_rdy", 64'(req_rdy), 64'(2'b10));
    check("t5 md_ab", {md_a, md_b}, {32'd2, 32'd3});
    @(posedge clk); #1;
    req_kill[0] = 1'b0;
    req_vld[1] = 1'b0;
    md_lat = 4;
    wait_resp(1, "t5 p1", res, lat);
    check("t5 p1 result", 64'(res[31:0]), 6);
    check("t5 p0 no resp", 64'(resp_cnt0 - c0), 0);

    // Kill in the same cycle as md_result_vld: no response, reuse dropped
    c0 = resp_cnt0;
    set_req(0, 1'b1, M_OP_REMU, 50, 7);
    wait_grant(0, "t6 remu", md_seen, ok);
    req_vld[0] = 1'b0;
    for (int t = 0; t < 100 && !md_result_vld; t++) begin
      @(posedge clk); #1;
    end
    check("t6 result seen", 64'(md_result_vld), 1);
    req_kill[0] = 1'b1;
    @(negedge clk);
    check("t6 resp_vld", 64'(resp_vld), 0);
    check("t6 md_kill", 64'(md_kill), 1);
    @(posedge clk); #1;
    req_kill[0] = 1'b0;
    check("t6 no resp", 64'(resp_cnt0 - c0), 0);
    run_op(0, M_OP_DIVU, 50, 7, 1'b0, "t6 divu", res);

    // Reset mid-BUSY: outputs drop at once, grant restarts from port0
    set_req(1, 1'b1, M_OP_MUL, 7, 8);
    wait_grant(1, "t7 mul", md_seen, ok);
    req_vld[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t7 rst outputs", {58'b0, req_rdy, resp_vld, md_vld, md_kill}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(0, 1'b1, M_OP_MUL, 9, 9);
    set_req(1, 1'b1, M_OP_MUL, 2, 2);
    @(negedge clk);
    check("t7 grant", 64'(req_rdy), 64'(2'b01));
    check("t7 md_vld", 64'(md_vld), 1);
    @(posedge clk); #1;
    req_vld[0] = 1'b0;
    wait_resp(0, "t7 p0", res, lat);
    check("t7 p0 result", 64'(res[31:0]), 81);
    wait_grant(1, "t7 p1", md_seen, ok);
    req_vld[1] = 1'b0;
    wait_resp(1, "t7 p1", res, lat);
    check("t7 p1 result", 64'(res[31:0]), 4);

    // Randomized single-port traffic against the reuse/arith model
    do_reset();
    m_vld = 1'b0; m_op = '0; m_a = '0; m_b = '0;
    for (int i = 0; i < 60; i++) begin
      p  = int'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      if (m_vld && $urandom_range(0, 1) == 1) begin
        a = m_a; b = m_b;
      end else begin
        a = $urandom;
        if ($urandom_range(0, 7) == 0) b = 0;
        else if ($urandom_range(0, 1) == 1) b = $urandom;
        else b = $urandom_range(1, 20);
      end
      md_lat = int'($urandom_range(1, 6));
      exp_hit = m_vld && (a == m_a) && (b == m_b) && pair_ok(m_op, op);
      run_op(p, op, a, b, exp_hit, "rnd", res);
      if (!exp_hit) begin
        m_vld = 1'b1; m_op = op; m_a = a; m_b = b;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
